// File: rtl/instr_fetch.sv
// Instruction fetch reader: issues in-order ROM reads at the PC address, tracks in-flight
// requests, and buffers returned {addr, data} words for decode behind a valid/ready handshake.
module instr_fetch #(
  parameter int DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic [15:0]                  i_pc_addr,
  output logic                         o_pc_inc,
  input  logic                         i_flush,
  output logic                         o_mem_req_valid,
  input  logic                         i_mem_req_ready,
  output logic [15:0]                  o_mem_addr,
  input  logic                         i_mem_rsp_valid,
  input  logic [15:0]                  i_mem_rsp_data,
  output logic                         o_ins_valid,
  input  logic                         i_ins_ready,
  output logic [15:0]                  o_ins_data,
  output logic [15:0]                  o_ins_addr,
  output logic [$clog2(DEPTH+1)-1:0]   o_dbg_outstanding,
  output logic [$clog2(DEPTH+1)-1:0]   o_dbg_count,
  output logic [$clog2(DEPTH+1)-1:0]   o_dbg_discard
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0] LIM = (CW+1)'(DEPTH);

  // Handshakes: a transfer happens on a channel in a cycle where its valid and ready are
  // both high at the rising edge; valid never depends on the ready of the same channel.

  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_discard;
  logic [AW-1:0] r_pend_wr;
  logic [AW-1:0] r_pend_rd;
  logic [AW-1:0] r_fifo_wr;
  logic [AW-1:0] r_fifo_rd;
  logic [15:0]   r_pend      [DEPTH];
  logic [15:0]   r_fifo_addr [DEPTH];
  logic [15:0]   r_fifo_data [DEPTH];

  logic [CW:0]   w_occ;
  logic          w_credit;
  logic          w_accept;
  logic          w_rsp;
  logic          w_push;
  logic          w_pop;

  // Credit uses registered occupancy only, so a same-cycle pop never frees a slot early.
  assign w_occ    = {1'b0, r_outstanding} + {1'b0, r_count};
  assign w_credit = (w_occ < LIM);

  assign o_mem_req_valid = i_reset_n && !i_flush && w_credit;
  assign o_mem_addr      = i_pc_addr;
  assign w_accept        = o_mem_req_valid && i_mem_req_ready;
  assign o_pc_inc        = w_accept;

  // A response with nothing outstanding is an environment error and is ignored.
  assign w_rsp  = i_mem_rsp_valid && (r_outstanding != '0);
  assign w_push = w_rsp && !i_flush && (r_discard == '0);

  assign o_ins_valid = (r_count != '0) && !i_flush;
  assign w_pop       = o_ins_valid && i_ins_ready;
  assign o_ins_data  = r_fifo_data[r_fifo_rd];
  assign o_ins_addr  = r_fifo_addr[r_fifo_rd];

  assign o_dbg_outstanding = r_outstanding;
  assign o_dbg_count       = r_count;
  assign o_dbg_discard     = r_discard;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_outstanding <= '0;
      r_count       <= '0;
      r_discard     <= '0;
      r_pend_wr     <= '0;
      r_pend_rd     <= '0;
      r_fifo_wr     <= '0;
      r_fifo_rd     <= '0;
    end else begin
      if (w_accept) r_pend_wr <= r_pend_wr + AW'(1);
      if (w_rsp)    r_pend_rd <= r_pend_rd + AW'(1);
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_rsp);
      if (i_flush) begin
        // Everything still in flight after this edge belongs to the old stream.
        r_count   <= '0;
        r_fifo_wr <= '0;
        r_fifo_rd <= '0;
        r_discard <= r_outstanding - CW'(w_rsp);
      end else begin
        if (w_rsp && (r_discard != '0)) r_discard <= r_discard - CW'(1);
        if (w_push) r_fifo_wr <= r_fifo_wr + AW'(1);
        if (w_pop)  r_fifo_rd <= r_fifo_rd + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset_n && w_accept) r_pend[r_pend_wr] <= i_pc_addr;
    if (i_reset_n && w_push) begin
      r_fifo_addr[r_fifo_wr] <= r_pend[r_pend_rd];
      r_fifo_data[r_fifo_wr] <= i_mem_rsp_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: PC and ROM behavioural models, directed scenarios, and a
// scoreboard queue of expected {addr, data} words checked by a monitor on every decode pop.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] pc_addr;
  logic        pc_inc;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [15:0] mem_addr;
  logic        mem_rsp_valid;
  logic [15:0] mem_rsp_data;
  logic        ins_valid;
  logic        ins_ready;
  logic [15:0] ins_data;
  logic [15:0] ins_addr;
  logic [2:0]  dbg_out;
  logic [2:0]  dbg_cnt;
  logic [2:0]  dbg_disc;

  instr_fetch #(.DEPTH(4)) dut (
    .i_clk             (clk),
    .i_reset_n         (reset_n),
    .i_pc_addr         (pc_addr),
    .o_pc_inc          (pc_inc),
    .i_flush           (flush),
    .o_mem_req_valid   (mem_req_valid),
    .i_mem_req_ready   (mem_req_ready),
    .o_mem_addr        (mem_addr),
    .i_mem_rsp_valid   (mem_rsp_valid),
    .i_mem_rsp_data    (mem_rsp_data),
    .o_ins_valid       (ins_valid),
    .i_ins_ready       (ins_ready),
    .o_ins_data        (ins_data),
    .o_ins_addr        (ins_addr),
    .o_dbg_outstanding (dbg_out),
    .o_dbg_count       (dbg_cnt),
    .o_dbg_discard     (dbg_disc)
  );

  // clock
  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          rom_lat = 1;
  logic [15:0] pc_rst_val = 16'd0;
  logic [15:0] flush_target = 16'd0;
  logic [31:0] exp_q[$];
  logic [15:0] rom_addr_q[$];
  int          rom_due_q[$];
  bit          s_inc, s_flush, s_rstn;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // PC and ROM models plus the scoreboard monitor; sampled at negedge, applied after posedge.
  initial begin : env
    logic [31:0] e;
    pc_addr = 16'd0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = 16'd0;
    forever begin
      @(negedge clk);
      s_inc = (pc_inc === 1'b1);
      s_flush = (flush === 1'b1);
      s_rstn = (reset_n === 1'b1);
      if (!s_rstn) begin
        rom_addr_q.delete();
        rom_due_q.delete();
      end else if (mem_req_valid === 1'b1 && mem_req_ready) begin
        rom_addr_q.push_back(mem_addr);
        rom_due_q.push_back(cyc + rom_lat);
      end
      if (ins_valid === 1'b1 && ins_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_ins: actual addr %0h data %0h required no instruction", ins_addr, ins_data);
        end else begin
          e = exp_q.pop_front();
          check("ins_stream", {ins_addr, ins_data}, e);
        end
      end
      @(posedge clk);
      cyc++;
      #1;
      if (!s_rstn) pc_addr = pc_rst_val;
      else if (s_flush) pc_addr = flush_target;
      else if (s_inc) pc_addr = pc_addr + 16'd1;
      if (rom_due_q.size() != 0 && rom_due_q[0] == cyc) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data = rom_addr_q[0] + 16'h1000;
        void'(rom_addr_q.pop_front());
        void'(rom_due_q.pop_front());
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data = 16'd0;
      end
    end
  end

  task automatic do_reset(input logic [15:0] pcv, input int ncyc);
    tick();
    reset_n = 1'b0;
    pc_rst_val = pcv;
    for (int i = 1; i < ncyc; i++) tick();
    @(negedge clk);
    check("reset_req_valid", mem_req_valid, 0);
    check("reset_pc_inc", pc_inc, 0);
    tick();
    reset_n = 1'b1;
  endtask

  task automatic push_range(input int first, input int last);
    for (int a = first; a <= last; a++) exp_q.push_back({16'(a), 16'(a) + 16'h1000});
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      tick();
      k++;
    end
    ins_ready = 1'b0;
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n_acc;
    reset_n = 1'b0;
    flush = 1'b0;
    ins_ready = 1'b0;
    mem_req_ready = 1'b1;

    // Stream: PC=25, L=1, continuous delivery from cycle 2
    rom_lat = 1;
    do_reset(16'd25, 2);
    ins_ready = 1'b1;
    exp_q.push_back({16'd25, 16'h1019});
    push_range(26, 34);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("reset_outstanding", dbg_out, 0);
        check("reset_count", dbg_cnt, 0);
        check("reset_discard", dbg_disc, 0);
        check("stream_first_accept", pc_inc, 1);
        check("stream_first_addr_req", mem_addr, 16'd25);
      end
      if (c < 2) check("stream_latency_valid", ins_valid, 0);
      else check("stream_no_gap", ins_valid, 1);
      if (c == 2) check("stream_first_ins", {ins_addr, ins_data}, {16'd25, 16'h1019});
      tick();
    end
    ins_ready = 1'b0;
    check("stream_delivered", exp_q.size(), 0);
    exp_q.delete();

    // Decode backpressure: exactly four accepts, then resume at 29
    do_reset(16'd25, 2);
    n_acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (pc_inc === 1'b1) n_acc++;
      tick();
    end
    @(negedge clk);
    check("bp_accepts", n_acc, 4);
    check("bp_req_valid_low", mem_req_valid, 0);
    check("bp_pc_stop", mem_addr, 16'd29);
    check("bp_count_full", dbg_cnt, 4);
    tick();
    push_range(25, 32);
    ins_ready = 1'b1;
    drain("bp_drain");

    // ROM stall: ready low 3 cycles at PC=40
    mem_req_ready = 1'b0;
    do_reset(16'd40, 2);
    ins_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_req_valid", mem_req_valid, 1);
      check("stall_addr_stable", mem_addr, 16'd40);
      check("stall_no_inc", pc_inc, 0);
      tick();
    end
    mem_req_ready = 1'b1;
    push_range(40, 42);
    @(negedge clk);
    check("stall_accept", pc_inc, 1);
    check("stall_accept_addr", mem_addr, 16'd40);
    drain("stall_drain");

    // Flush with two in flight and one buffered, L=3, target 527
    rom_lat = 3;
    do_reset(16'd100, 2);
    tick(); mem_req_ready = 1'b0;
    tick(); mem_req_ready = 1'b1;
    tick();
    tick();
    flush = 1'b1;
    flush_target = 16'd527;
    ins_ready = 1'b1;
    exp_q.push_back({16'd527, 16'h120F});
    push_range(528, 529);
    @(negedge clk);
    check("flush_ins_valid", ins_valid, 0);
    check("flush_req_valid", mem_req_valid, 0);
    check("flush_pc_inc", pc_inc, 0);
    check("flush_pre_count", dbg_cnt, 1);
    check("flush_pre_outstanding", dbg_out, 2);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_discard", dbg_disc, 2);
    check("flush_count_clear", dbg_cnt, 0);
    check("flush_ins_valid_after", ins_valid, 0);
    check("flush_redirect_addr", mem_addr, 16'd527);
    check("flush_redirect_inc", pc_inc, 1);
    drain("flush_drain");

    // Flush coinciding with a response while decode is ready
    rom_lat = 2;
    do_reset(16'd200, 2);
    ins_ready = 1'b1;
    tick();
    tick();
    tick();
    flush = 1'b1;
    flush_target = 16'd300;
    push_range(300, 302);
    @(negedge clk);
    check("flushrsp_rsp_present", mem_rsp_valid, 1);
    check("flushrsp_ins_valid", ins_valid, 0);
    check("flushrsp_pre_outstanding", dbg_out, 2);
    check("flushrsp_pre_count", dbg_cnt, 1);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flushrsp_discard", dbg_disc, 1);
    check("flushrsp_outstanding", dbg_out, 1);
    check("flushrsp_count", dbg_cnt, 0);
    check("flushrsp_redirect", mem_addr, 16'd300);
    drain("flushrsp_drain");

    // Reset mid-stream with three buffered entries
    rom_lat = 1;
    do_reset(16'd400, 2);
    tick();
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    pc_rst_val = 16'd700;
    @(negedge clk);
    check("midrst_buffered", dbg_cnt, 3);
    check("midrst_req_valid", mem_req_valid, 0);
    tick();
    reset_n = 1'b1;
    ins_ready = 1'b1;
    push_range(700, 702);
    @(negedge clk);
    check("midrst_ins_valid", ins_valid, 0);
    check("midrst_outstanding", dbg_out, 0);
    check("midrst_count", dbg_cnt, 0);
    check("midrst_discard", dbg_disc, 0);
    check("midrst_first_addr", mem_addr, 16'd700);
    drain("midrst_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch reader sitting between the program counter and instruction ROM. It consumes the PC's 16-bit output address, issues in-order ROM read requests, and pulses the PC's `inc` input each time a request is accepted. Returned words are buffered with their addresses in a small FIFO and presented to decode over a valid/ready handshake. A flush input discards buffered and in-flight fetches when the core loads the PC for a jump.

## Interface
- `DEPTH`, 4: total fetch slots, counting outstanding requests plus FIFO entries; power of two, ≥2.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  synchronous reset, active-low.
- `pc_addr`  in  16  current PC output.
- `pc_inc`  out  1  increment strobe to PC; equals request accept.
- `flush`  in  1  one-cycle pulse, asserted in the same cycle the core asserts PC `load`.
- `mem_req_valid`  out  1  ROM read request valid.
- `mem_req_ready`  in  1  ROM accepts request.
- `mem_addr`  out  16  request address; always equals `pc_addr`.
- `mem_rsp_valid`  in  1  ROM response valid; in order, latency ≥1 cycle after accept.
- `mem_rsp_data`  in  16  ROM response word.
- `ins_valid`  out  1  instruction available to decode.
- `ins_ready`  in  1  decode accepts instruction.
- `ins_data`  out  16  instruction word (FIFO head).
- `ins_addr`  out  16  address of `ins_data`.

## Operation
- Registered state:
  - `outstanding`, 0..DEPTH: accepted requests not yet responded to.
  - `count`, 0..DEPTH: FIFO occupancy.
  - `discard`, 0..DEPTH: responses still to drop after a flush.
  - Pending-address queue, DEPTH entries: addresses of outstanding requests.
  - Data FIFO, DEPTH entries of {addr, data}.
- Credit: `mem_req_valid = !flush && (outstanding + count < DEPTH)`. Use registered values only; a same-cycle pop does not grant credit.
- Accept = `mem_req_valid && mem_req_ready`.
  - `pc_inc = accept`, combinational.
  - Push `pc_addr` into the pending queue.
  - `outstanding` increments.
- While valid is high and ready is low, `mem_addr` stays stable: the PC does not move because `pc_inc` = 0.
- Response (`mem_rsp_valid`):
  - Pop the pending-address queue.
  - `outstanding` decrements.
  - If `discard` > 0, drop the response and decrement `discard`.
  - Otherwise push {popped addr, `mem_rsp_data`} into the FIFO.
- Pop: `ins_valid && ins_ready`. `ins_valid = (count > 0) && !flush`.
- Flush cycle:
  - No request, no `pc_inc`, no FIFO pop.
  - At the edge, clear FIFO and `count`.
  - `discard` ← `outstanding` minus 1 if a response is present this cycle, else `outstanding`. The same-cycle response is dropped.
  - `outstanding` and the pending queue update normally.
- Flush while `discard` > 0 recomputes `discard` the same way; stale counts never accumulate.
- Overflow cannot occur by the credit rule. A response with `outstanding` = 0 is an environment error and is ignored.

## Timing
- Reset (`reset_n` low at an edge):
  - `outstanding`, `count`, `discard` and queue pointers go to 0.
  - From the next cycle: `ins_valid` = 0, `mem_req_valid` = 0 while `reset_n` is low, `pc_inc` = 0.
  - Responses sampled while in reset are ignored. ROM and PC are reset together with this block.
- Reset mid-operation drops all buffered and in-flight data; no response from before reset is ever delivered.
- Throughput: one accept per cycle. With ROM latency L and `ins_ready` = 1:
  - Accept at cycle N, response at N+L.
  - `ins_valid` at N+L+1. The FIFO is registered; there is no bypass.
- Sustained one instruction per cycle when DEPTH ≥ L+1.
- FIFO push and pop in the same cycle are legal at any occupancy, including full.
- Flush redirect: PC loads at the flush edge. The first request for the new target is issued the cycle after flush.

## Test plan
- Stream: `reset_n` low 2 cycles, PC=25, ROM[a]=a+16'h1000, L=1, `ins_ready`=1 → first accept cycle 0, `ins_valid` cycle 2 with addr 25/data 16'h1019, then 26, 27 … every cycle, no gaps.
- Decode backpressure: `ins_ready`=0 from reset, L=1 → exactly 4 accepts, PC stops at 29, `mem_req_valid` low. Release → addrs 25..28 delivered in order, fetch resumes at 29, no duplicates.
- ROM stall: `mem_req_ready` low 3 cycles at PC=40 → `mem_req_valid`=1, `mem_addr`=40 stable, `pc_inc`=0 for 3 cycles; accept on cycle 4.
- Flush with in-flight: L=3, 2 outstanding, 1 buffered, flush with PC load to 527 → `ins_valid` low in flush cycle, both stale responses dropped, next delivered addr 527/data 16'h120F.
- Flush coinciding with a response and `ins_ready`=1 → response dropped, no pop counted, `discard` = outstanding−1.
- Reset mid-stream: 3 entries buffered, `reset_n` low 1 cycle → `ins_valid`=0 next cycle, counters 0, first post-reset instruction is the address on `pc_addr` after reset.
